// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bundle between the PC sequencer and the decode/hazard/imem side.
// master = the sequencer; slave = its environment.
interface fetch_sequencer_if;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_target;
  logic        halt_dec;
  logic        imem_rdy;
  logic        imem_req;
  logic [15:0] pc;
  logic [15:0] pc_seq;
  logic        if_valid;
  logic        flush;
  logic        halted;
  logic [15:0] stall_cycles;

  modport master (
    input  stall, br_taken, br_target, halt_dec, imem_rdy,
    output imem_req, pc, pc_seq, if_valid, flush, halted, stall_cycles
  );

  modport slave (
    output stall, br_taken, br_target, halt_dec, imem_rdy,
    input  imem_req, pc, pc_seq, if_valid, flush, halted, stall_cycles
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC sequencer: sequential step, branch redirect, stall/miss hold, HLT freeze.
// Optional fetch-bubble counter enabled by defining FETCH_PERF_EN.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, MISS, HALT} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        if_valid;
  logic        flush;
  logic        active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign active = (state_q == FETCH) || (state_q == MISS);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    if_valid = 1'b0;
    flush    = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH, MISS: begin
        // Priority order matters: a stall masks branch and halt so the hazard unit can replay them.
        if (bus.stall) begin
          state_d = state_q;
        end else if (bus.halt_dec) begin
          state_d = HALT;
          flush   = 1'b1;
        end else if (bus.br_taken) begin
          pc_d    = bus.br_target & 16'hFFFE;
          state_d = FETCH;
          flush   = 1'b1;
        end else if (bus.imem_rdy) begin
          pc_d     = pc_q + 16'd2;
          state_d  = FETCH;
          if_valid = 1'b1;
        end else begin
          state_d = MISS;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  assign bus.pc       = pc_q;
  assign bus.pc_seq   = pc_q + 16'd2;
  assign bus.imem_req = active;
  assign bus.halted   = (state_q == HALT);
  assign bus.if_valid = if_valid;
  assign bus.flush    = flush;

`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Counts bubbles only: cycles fetch was live but delivered nothing and squashed nothing.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (active && !if_valid && !flush && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= 16'h0000;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign bus.stall_cycles = stall_cnt_q;
`else
  assign bus.stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a mode-level reference model checked every
// falling edge, plus literal expectations at the key points of each scenario.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int asserts  = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] perf(input int n);
`ifdef FETCH_PERF_EN
    return 16'(n);
`else
    return 16'(0 * n);
`endif
  endfunction

  // Reference model: 0 = waiting after reset, 1 = fetching (hit or miss alike), 2 = halted.
  int m_mode = 0;
  int m_pc   = 0;
  int m_cnt  = 0;
  int n_mode, n_pc, n_cnt;

  always @(negedge clk) begin
    int e_valid, e_flush;
    e_valid = 0;
    e_flush = 0;
    n_mode  = m_mode;
    n_pc    = m_pc;
    n_cnt   = m_cnt;
    if (m_mode == 0) begin
      n_mode = 1;
    end else if (m_mode == 1 && bus.stall !== 1'b1) begin
      if (bus.halt_dec === 1'b1) begin
        e_flush = 1;
        n_mode  = 2;
      end else if (bus.br_taken === 1'b1) begin
        e_flush = 1;
        n_pc    = int'(bus.br_target) - (int'(bus.br_target) % 2);
      end else if (bus.imem_rdy === 1'b1) begin
        e_valid = 1;
        n_pc    = (m_pc + 2) % 65536;
      end
    end
`ifdef FETCH_PERF_EN
    if (m_mode == 1 && e_valid == 0 && e_flush == 0 && m_cnt < 65535) n_cnt = m_cnt + 1;
`endif
    chk("model_pc",       bus.pc,           16'(m_pc));
    chk("model_pc_seq",   bus.pc_seq,       16'((m_pc + 2) % 65536));
    chk("model_imem_req", 16'(bus.imem_req), 16'(m_mode == 1));
    chk("model_halted",   16'(bus.halted),   16'(m_mode == 2));
    chk("model_if_valid", 16'(bus.if_valid), 16'(e_valid));
    chk("model_flush",    16'(bus.flush),    16'(e_flush));
    chk("model_stall_cnt", bus.stall_cycles, 16'(m_cnt));
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0;
      m_pc   <= 0;
      m_cnt  <= 0;
    end else begin
      m_mode <= n_mode;
      m_pc   <= n_pc;
      m_cnt  <= n_cnt;
    end
  end

  int cyc = 0;
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d rst=%0b pc=%h req=%0b valid=%0b flush=%0b halted=%0b cnt=%0d",
             cyc, rst, bus.pc, bus.imem_req, bus.if_valid, bus.flush, bus.halted, bus.stall_cycles);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.stall = 0; bus.br_taken = 0; bus.br_target = 16'h0000;
    bus.halt_dec = 0; bus.imem_rdy = 1;
    step(); step();
    chk("rst_pc", bus.pc, 16'h0000);
    chk("rst_pc_seq", bus.pc_seq, 16'h0002);
    chk("rst_req", 16'(bus.imem_req), 16'h0);
    chk("rst_halted", 16'(bus.halted), 16'h0);
    chk("rst_cnt", bus.stall_cycles, 16'h0000);
    chk("pin_model_pc", 16'(m_pc), 16'h0000);

    // Reset release with imem_rdy=1: one idle cycle, then 0000, 0002, 0004...
    rst = 0; #1;
    chk("idle_req", 16'(bus.imem_req), 16'h0);
    step();
    chk("first_pc", bus.pc, 16'h0000);
    chk("first_valid", 16'(bus.if_valid), 16'h1);
    step(); chk("seq_pc2", bus.pc, 16'h0002);
    step(); chk("seq_pc4", bus.pc, 16'h0004);
    repeat (6) step();
    chk("seq_pc10", bus.pc, 16'h0010);

    // Three-cycle miss at 0x0010
    bus.imem_rdy = 0; #1;
    chk("miss_valid0", 16'(bus.if_valid), 16'h0);
    step();
    chk("miss_req", 16'(bus.imem_req), 16'h1);
    chk("miss_pc", bus.pc, 16'h0010);
    step(); step();
    bus.imem_rdy = 1; #1;
    chk("miss_cnt3", bus.stall_cycles, perf(3));
    chk("miss_pc_hold", bus.pc, 16'h0010);
    chk("miss_end_valid", 16'(bus.if_valid), 16'h1);
    step(); chk("after_miss_pc", bus.pc, 16'h0012);
    repeat (7) step();
    chk("pc20", bus.pc, 16'h0020);

    // Branch while in MISS at 0x0020
    bus.imem_rdy = 0;
    step();
    bus.br_taken = 1; bus.br_target = 16'h0101; #1;
    chk("br_miss_flush", 16'(bus.flush), 16'h1);
    chk("br_miss_valid", 16'(bus.if_valid), 16'h0);
    step();
    bus.br_taken = 0; bus.imem_rdy = 1; #1;
    chk("br_miss_pc", bus.pc, 16'h0100);
    chk("br_miss_req", 16'(bus.imem_req), 16'h1);
    chk("br_miss_cnt", bus.stall_cycles, perf(4));

    // Stall masks a branch
    bus.stall = 1; bus.br_taken = 1; bus.br_target = 16'h0400; #1;
    chk("stall_flush", 16'(bus.flush), 16'h0);
    step();
    chk("stall_pc", bus.pc, 16'h0100);
    bus.stall = 0; #1;
    chk("unstall_flush", 16'(bus.flush), 16'h1);
    step();
    bus.br_taken = 0;
    chk("unstall_pc", bus.pc, 16'h0400);

    // Wrap then halt
    bus.br_taken = 1; bus.br_target = 16'hFFFF;
    step();
    bus.br_taken = 0; #1;
    chk("wrap_pc", bus.pc, 16'hFFFE);
    chk("wrap_pc_seq", bus.pc_seq, 16'h0000);
    step();
    chk("wrapped_pc", bus.pc, 16'h0000);
    bus.halt_dec = 1; #1;
    chk("halt_flush", 16'(bus.flush), 16'h1);
    step();
    bus.halt_dec = 0;
    for (int i = 0; i < 10; i++) begin
      bus.br_taken = 1'(i % 2); bus.br_target = 16'h1234;
      bus.imem_rdy = 1'(i % 3 != 0); bus.stall = 1'(i == 4); #1;
      chk("halt_halted", 16'(bus.halted), 16'h1);
      chk("halt_req", 16'(bus.imem_req), 16'h0);
      chk("halt_flush0", 16'(bus.flush), 16'h0);
      step();
    end
    chk("halt_pc", bus.pc, 16'h0000);
    bus.br_taken = 0; bus.stall = 0; bus.imem_rdy = 1;
    rst = 1; #1;
    chk("halt_rst_halted", 16'(bus.halted), 16'h0);
    chk("halt_rst_pc", bus.pc, 16'h0000);
    chk("halt_rst_cnt", bus.stall_cycles, 16'h0000);

    // Reset mid-miss at a nonzero pc
    step();
    rst = 0;
    repeat (4) step();
    chk("pc6", bus.pc, 16'h0006);
    bus.imem_rdy = 0;
    step(); step();
    chk("mid_miss_cnt", bus.stall_cycles, perf(2));
    rst = 1; #1;
    chk("mid_miss_rst_pc", bus.pc, 16'h0000);
    chk("mid_miss_rst_req", 16'(bus.imem_req), 16'h0);
    chk("mid_miss_rst_cnt", bus.stall_cycles, 16'h0000);
    step();
    rst = 0; bus.imem_rdy = 1;
    step(); step();
    chk("restart_pc", bus.pc, 16'h0002);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences the fetch-stage program counter of the 16-bit pipelined core. It owns the PC register and steps it sequentially (PC+2) on each delivered instruction. It redirects the PC when the decode stage resolves a taken branch, holds it on hazard stalls and instruction-memory misses, and freezes fetch permanently on HLT. It sits between the decode-stage branch-condition logic, the hazard unit and the instruction cache, and drives the IF/ID pipeline register's valid and flush controls.

## Interface
- RESET_PC, 16'h0000, PC value loaded by reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hazard unit: hold PC and IF/ID this cycle
- br_taken  in  1  decode stage: branch/jump resolved taken this cycle
- br_target  in  16  redirect address; bit 0 ignored (forced to 0)
- halt_dec  in  1  decode stage: HLT decoded this cycle
- imem_rdy  in  1  instruction at address pc is available this cycle
- imem_req  out  1  fetch request to instruction memory at address pc
- pc  out  16  current fetch address
- pc_seq  out  16  pc + 2, mod 2^16, passed into IF/ID
- if_valid  out  1  IF/ID captures a valid instruction this cycle
- flush  out  1  squash the IF/ID contents this cycle
- halted  out  1  fetch permanently stopped
- stall_cycles  out  16  fetch-bubble counter (see Configuration)

## Operation
- States: IDLE, FETCH, MISS, HALT. Reset enters IDLE, pc=RESET_PC.
- IDLE: imem_req=0. Always goes to FETCH next cycle. Ignores all inputs.
- FETCH and MISS: imem_req=1. Each cycle, the first matching rule applies.
  1. stall=1: pc holds, state holds, if_valid=0, flush=0. br_taken and halt_dec are ignored; the hazard unit re-presents them.
  2. halt_dec=1: go to HALT, pc holds, flush=1, if_valid=0.
  3. br_taken=1: pc←{br_target[15:1],1'b0}, go to FETCH, flush=1, if_valid=0. An outstanding miss is abandoned.
  4. imem_rdy=1: pc←pc+2, go to FETCH, if_valid=1.
  5. Otherwise: pc holds, go to MISS, if_valid=0.
- HALT: imem_req=0, halted=1, if_valid=0, flush=0, pc frozen. All inputs are ignored. Only rst exits HALT.
- Arithmetic: pc+2 wraps, so 16'hFFFE→16'h0000. No error or flag is raised on wrap.
- pc_seq = pc+2 at all times, including in IDLE and HALT.

## Timing
- pc, state and stall_cycles are registered. if_valid and flush are combinational from state and current inputs. imem_req and halted depend on state only.
- Reset values (asynchronous, while rst=1): pc=RESET_PC, pc_seq=RESET_PC+2, imem_req=0, if_valid=0, flush=0, halted=0, stall_cycles=0.
- First request: imem_req rises 1 cycle after rst deasserts.
- Branch redirect: br_taken in cycle n gives pc=target with imem_req=1 in cycle n+1. The wrong-path bubble is 1 cycle (flush in cycle n).
- Hit throughput: 1 instruction per cycle while imem_rdy=1 and stall=0.
- Miss: if_valid is first asserted in the cycle imem_rdy rises. No added latency on top of memory.
- Reset mid-miss or mid-HALT clears everything immediately. No pending state survives.

## Configuration
- FETCH_PERF_EN defined:
  - stall_cycles increments in each FETCH/MISS cycle with if_valid=0 and flush=0 (stall or miss bubbles).
  - It saturates at 16'hFFFF and is cleared only by rst.
- FETCH_PERF_EN undefined: no counter register. stall_cycles is tied to 16'h0000.

## Test plan
- Reset release, imem_rdy=1 constant: imem_req=0 for 1 cycle, then pc steps 0000, 0002, 0004… with if_valid=1 each cycle.
- Miss: at pc=0x0010, hold imem_rdy=0 for 3 cycles. Required: state is MISS, pc stays 0x0010, if_valid=0, and stall_cycles=3 with FETCH_PERF_EN.
- Branch during miss: at pc=0x0020 in MISS, br_taken=1 with br_target=0x0101. Required: flush=1 that cycle, and next cycle pc=0x0100 in FETCH.
- Stall masks branch: stall=1 and br_taken=1 with target 0x0400. Required: pc unchanged, flush=0. One cycle later, stall=0 and br_taken=1: pc=0x0400.
- Halt and wrap:
  - Start at pc=0xFFFE with imem_rdy=1: next pc=0x0000.
  - Then halt_dec=1: flush=1, then halted=1 and imem_req=0 held for 10 cycles regardless of br_taken.
  - Then rst=1: halted=0 and pc=0x0000 immediately.
